// File: rtl/rf_ctrl_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
// Grant sources, arbitration states and the hard-wired zero register index.
package rf_ctrl_pkg;

  typedef enum logic {
    NORMAL = 1'b0,
    DRAIN  = 1'b1
  } arb_state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_WB   = 2'd1,
    GNT_MC   = 2'd2
  } grant_t;

  localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/rf_wb_fifo.sv
// Small synchronous FIFO holding {rd, data} multi-cycle results.
// The head entry is visible combinationally so a pop can be written in the same cycle.
module rf_wb_fifo #(
  parameter int AW    = 5,
  parameter int DW    = 32,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic [AW-1:0] i_push_rd,
  input  logic [DW-1:0] i_push_data,
  input  logic          i_pop,
  output logic [AW-1:0] o_head_rd,
  output logic [DW-1:0] o_head_data,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW+DW-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign w_push_ok = i_push & ~o_full;
  assign w_pop_ok  = i_pop & ~o_empty;

  assign {o_head_rd, o_head_data} = r_mem[r_rd_ptr];

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= {i_push_rd, i_push_data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      if (w_push_ok && !w_pop_ok) begin
        r_count <= r_count + CW'(1);
      end else if (!w_push_ok && w_pop_ok) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Arbitrates the register file write port between pipeline writeback and buffered
// multi-cycle results, with a bounded-wait drain and a pending-write scoreboard.
module rf_wb_arbiter
  import rf_ctrl_pkg::*;
#(
  parameter int REG_FILE_ADDR_WIDTH = 5,
  parameter int DATA_WIDTH          = 32,
  parameter int FIFO_DEPTH          = 2,
  parameter int MAX_WAIT            = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           wb_valid,
  input  logic [REG_FILE_ADDR_WIDTH-1:0] wb_rd,
  input  logic [DATA_WIDTH-1:0]          wb_data,
  input  logic                           mc_issue,
  input  logic [REG_FILE_ADDR_WIDTH-1:0] mc_issue_rd,
  input  logic                           mc_valid,
  input  logic [REG_FILE_ADDR_WIDTH-1:0] mc_rd,
  input  logic [DATA_WIDTH-1:0]          mc_data,
  output logic                           mc_ready,
  input  logic [REG_FILE_ADDR_WIDTH-1:0] rs1,
  input  logic [REG_FILE_ADDR_WIDTH-1:0] rs2,
  input  logic [REG_FILE_ADDR_WIDTH-1:0] dec_rd,
  output logic                           hazard_stall,
  output logic                           pipe_stall,
  output logic                           WE3,
  output logic [REG_FILE_ADDR_WIDTH-1:0] AD3,
  output logic [DATA_WIDTH-1:0]          WD3
);

  localparam int AW    = REG_FILE_ADDR_WIDTH;
  localparam int DW    = DATA_WIDTH;
  localparam int NREGS = 2 ** AW;
  localparam int CW    = $clog2(FIFO_DEPTH + 1);
  localparam int WCW   = $clog2(MAX_WAIT + 1);
  localparam logic [AW-1:0] W_ZERO_RD = AW'(REG_ZERO);

  arb_state_t     r_state;
  logic [WCW-1:0] r_wait_cnt;
  logic [NREGS-1:0] r_busy;

  grant_t          w_grant;
  logic            w_push;
  logic            w_pop;
  logic            w_wb_lost;
  logic [AW-1:0]   w_head_rd;
  logic [DW-1:0]   w_head_data;
  logic            w_full;
  logic            w_empty;
  logic [CW-1:0]   w_count;
  logic [NREGS-1:0] w_set;
  logic [NREGS-1:0] w_clr;

  assign mc_ready = (w_count != CW'(FIFO_DEPTH));
  assign w_push   = mc_valid & ~w_full;

  rf_wb_fifo #(
    .AW    (AW),
    .DW    (DW),
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_push_rd   (mc_rd),
    .i_push_data (mc_data),
    .i_pop       (w_pop),
    .o_head_rd   (w_head_rd),
    .o_head_data (w_head_data),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (w_count)
  );

  // Grant is masked during reset so a live wb_valid cannot write while rst_n is low.
  always_comb begin
    w_grant = GNT_NONE;
    if (!rst_n) begin
      w_grant = GNT_NONE;
    end else if (r_state == DRAIN) begin
      w_grant = w_empty ? GNT_NONE : GNT_MC;
    end else if (wb_valid) begin
      w_grant = GNT_WB;
    end else if (!w_empty) begin
      w_grant = GNT_MC;
    end
  end

  assign w_pop      = (w_grant == GNT_MC);
  assign w_wb_lost  = (r_state == NORMAL) && (w_grant == GNT_WB) && !w_empty;
  assign pipe_stall = (r_state == DRAIN);

  always_comb begin
    WE3 = 1'b0;
    AD3 = '0;
    WD3 = '0;
    if (w_grant == GNT_WB) begin
      AD3 = wb_rd;
      WD3 = wb_data;
      WE3 = (wb_rd != W_ZERO_RD);
    end else if (w_grant == GNT_MC) begin
      AD3 = w_head_rd;
      WD3 = w_head_data;
      WE3 = (w_head_rd != W_ZERO_RD);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= NORMAL;
      r_wait_cnt <= '0;
    end else if (r_state == DRAIN) begin
      if (w_pop) begin
        r_state    <= NORMAL;
        r_wait_cnt <= '0;
      end
    end else begin
      if (w_pop) begin
        r_wait_cnt <= '0;
      end else if (w_wb_lost) begin
        if (r_wait_cnt == WCW'(MAX_WAIT - 1)) begin
          r_state    <= DRAIN;
          r_wait_cnt <= '0;
        end else begin
          r_wait_cnt <= r_wait_cnt + WCW'(1);
        end
      end
    end
  end

  // Per-register set/clear; x0 can never be set, so it never reads busy.
  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_sb
      if (gi == 0) begin : g_zero
        assign w_set[gi] = 1'b0;
      end else begin : g_reg
        assign w_set[gi] = mc_issue && (mc_issue_rd == AW'(gi));
      end
      assign w_clr[gi] = w_pop && (w_head_rd == AW'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= (r_busy & ~w_clr) | w_set;
    end
  end

  assign hazard_stall = ((rs1    != W_ZERO_RD) && r_busy[rs1])
                      | ((rs2    != W_ZERO_RD) && r_busy[rs2])
                      | ((dec_rd != W_ZERO_RD) && r_busy[dec_rd]);

endmodule
